ps2_scan_parser: RTL and testbench

- Sits between ps2_rx and the key decoder. Consumes raw bytes qualified by ps2_rx's rx_done_tick.
- Strips the E0 (extended) and F0 (break) prefixes and emits one key event per make/break sequence: code, extended flag and break flag.
- Buffers events in a small show-ahead FIFO with valid/ready handout.
- Recovers from truncated sequences with a watchdog. This replaces the periodic blind reset of the receiver path.

---
 rtl/ps2_scan_parser_if.sv | 27 ++
 rtl/ps2_scan_parser.sv | 158 +++++++++++++++
 tb/tb_ps2_scan_parser.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_parser_if.sv
// Handshake bundle between ps2_rx, the scan-code parser and the key decoder.
// slave = parser view, master = producer/consumer view.
interface ps2_scan_parser_if #(
  parameter int unsigned FIFO_AW = 2
);
  logic             rx_done_tick;
  logic [7:0]       din;
  logic             ev_ready;
  logic             ovf_clr;
  logic             ev_valid;
  logic [7:0]       ev_code;
  logic             ev_ext;
  logic             ev_break;
  logic [FIFO_AW:0] level;
  logic             overflow;
  logic             seq_err;

  modport slave (
    input  rx_done_tick, din, ev_ready, ovf_clr,
    output ev_valid, ev_code, ev_ext, ev_break, level, overflow, seq_err
  );

  modport master (
    output rx_done_tick, din, ev_ready, ovf_clr,
    input  ev_valid, ev_code, ev_ext, ev_break, level, overflow, seq_err
  );
endinterface

// File: rtl/ps2_scan_parser.sv
// Strips E0/F0 prefixes from PS/2 scan bytes, queues one event per key sequence
// in a show-ahead FIFO, and aborts stalled sequences with a watchdog.
module ps2_scan_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 12500000,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned FIFO_AW        = 2
) (
  input  logic                clk,
  input  logic                reset,
  ps2_scan_parser_if.slave    bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned EV_W  = 10;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PE0   = 2'd1;
  localparam logic [1:0] ST_PF0   = 2'd2;
  localparam logic [1:0] ST_PE0F0 = 2'd3;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;

  logic [1:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               seq_err_q, seq_err_d;
  logic               overflow_q, overflow_d;
  logic [FIFO_AW:0]   level_q,   level_d;
  logic [FIFO_AW-1:0] wr_ptr_q,  rd_ptr_q;
  logic [EV_W-1:0]    mem_q [DEPTH];

  logic               push_c;
  logic [EV_W-1:0]    push_ev_c;
  logic               pop_c;
  logic               wr_en_c;
  logic               ovf_set_c;
  logic [EV_W-1:0]    head_c;

  // Prefix FSM and watchdog; a byte in the timeout cycle wins over the abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_err_d = 1'b0;
    push_c    = 1'b0;
    push_ev_c = {bus.din, 2'b00};

    if (bus.rx_done_tick) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (bus.din)
            B_E0: state_d = ST_PE0;
            B_F0: state_d = ST_PF0;
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_d = ST_IDLE;
            default: push_c = 1'b1;
          endcase
        end
        ST_PE0: begin
          if (bus.din == B_F0) begin
            state_d = ST_PE0F0;
          end else if (bus.din != B_E0) begin
            push_c    = 1'b1;
            push_ev_c = {bus.din, 2'b10};
            state_d   = ST_IDLE;
          end
        end
        ST_PF0: begin
          state_d = ST_IDLE;
          if (bus.din == B_E0 || bus.din == B_F0) begin
            seq_err_d = 1'b1;
          end else begin
            push_c    = 1'b1;
            push_ev_c = {bus.din, 2'b01};
          end
        end
        default: begin
          state_d = ST_IDLE;
          if (bus.din == B_E0 || bus.din == B_F0) begin
            seq_err_d = 1'b1;
          end else begin
            push_c    = 1'b1;
            push_ev_c = {bus.din, 2'b11};
          end
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = ST_IDLE;
        seq_err_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    pop_c      = (level_q != '0) && bus.ev_ready;
    wr_en_c    = push_c && ((level_q != LVL_FULL) || pop_c);
    ovf_set_c  = push_c && (level_q == LVL_FULL) && !pop_c;
    overflow_d = overflow_q;
    if (bus.ovf_clr) overflow_d = 1'b0;
    if (ovf_set_c)   overflow_d = 1'b1;
    level_d = level_q;
    case ({wr_en_c, pop_c})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      seq_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seq_err_q  <= seq_err_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_c)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q] <= push_ev_c;
    end
  end

  // Head fields read as zero while the FIFO is empty.
  assign head_c       = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.ev_valid = (level_q != '0);
  assign bus.ev_code  = head_c[9:2];
  assign bus.ev_ext   = head_c[1];
  assign bus.ev_break = head_c[0];
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_ps2_scan_parser.sv
// Bench for ps2_scan_parser: directed scenarios plus random bytes, all checked
// each cycle against a prefix-flag / event-queue reference model.
module tb_ps2_scan_parser;

  localparam int unsigned TOUT    = 100;
  localparam int unsigned CNT_W   = 24;
  localparam int unsigned FIFO_AW = 2;
  localparam int          DEPTH   = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  ps2_scan_parser_if #(.FIFO_AW(FIFO_AW)) bus ();

  ps2_scan_parser #(
    .TIMEOUT_CYCLES(TOUT),
    .CNT_W(CNT_W),
    .FIFO_AW(FIFO_AW)
  ) dut (
    .clk(clk),
    .reset(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: events as {code, ext, brk}; a sequence is "open" after a prefix.
  logic [9:0] m_q [$];
  bit         m_open, m_ext, m_brk, m_ovf, m_err;
  int         m_cyc  = 0;
  int         m_last = 0;

  logic [7:0] drop_tab [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic bit is_drop(input logic [7:0] b);
    foreach (drop_tab[i]) if (drop_tab[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    logic [9:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 10'h0;
    check("ev_valid", 32'(bus.ev_valid), 32'(m_q.size() != 0));
    check("ev_code",  32'(bus.ev_code),  32'(h[9:2]));
    check("ev_ext",   32'(bus.ev_ext),   32'(h[1]));
    check("ev_break", 32'(bus.ev_break), 32'(h[0]));
    check("level",    32'(bus.level),    32'(m_q.size()));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("seq_err",  32'(bus.seq_err),  32'(m_err));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_open = 0; m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit tick, input logic [7:0] b, input bit rdy, input bit clr);
    bit         push;
    logic [9:0] ev;
    push  = 0;
    ev    = '0;
    m_err = 0;
    if (tick) begin
      m_last = m_cyc;
      if (b == 8'hE0 || b == 8'hF0) begin
        if (m_open && m_brk) begin
          m_err = 1; m_open = 0; m_ext = 0; m_brk = 0;
        end else begin
          m_open = 1;
          if (b == 8'hE0) m_ext = 1; else m_brk = 1;
        end
      end else if (m_open) begin
        push = 1; ev = {b, m_ext, m_brk};
        m_open = 0; m_ext = 0; m_brk = 0;
      end else if (!is_drop(b)) begin
        push = 1; ev = {b, 2'b00};
      end
    end else if (m_open && (m_cyc - m_last) == int'(TOUT)) begin
      m_err = 1; m_open = 0; m_ext = 0; m_brk = 0;
    end
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (clr) m_ovf = 0;
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else m_ovf = 1;
    end
    m_cyc++;
  endtask

  // One clock: check state left by the previous edge, drive inputs, advance model.
  task automatic cycle(input bit tick, input logic [7:0] b, input bit rdy, input bit clr);
    check_outputs();
    bus.rx_done_tick = tick;
    bus.din          = b;
    bus.ev_ready     = rdy;
    bus.ovf_clr      = clr;
    model_edge(tick, b, rdy, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    cycle(1'b1, b, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy, 1'b0);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.din          = 8'h00;
    bus.ev_ready     = 1'b0;
    bus.ovf_clr      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // Plain make and break
    send(8'h1C, 1); idle(1, 1);
    send(8'hF0, 1); send(8'h1C, 1); idle(2, 1);

    // Extended make/break, silently dropped bytes
    send(8'hE0, 1); send(8'h75, 1); idle(1, 1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1); idle(1, 1);
    send(8'hAA, 1); send(8'hFA, 1); idle(2, 1);

    // Fill past capacity, drain, clear overflow
    send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0);
    send(8'h2D, 0); send(8'h2C, 0); send(8'h35, 0);
    idle(2, 0);
    idle(5, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1, 0);

    // Push and pop on the same edge while full
    send(8'h11, 0); send(8'h12, 0); send(8'h13, 0); send(8'h14, 0);
    send(8'h3C, 1);
    idle(1, 0);
    idle(5, 1);

    // Watchdog abort, then clean sequence, then illegal prefix order
    send(8'hE0, 1); idle(TOUT + 5, 1);
    send(8'h1C, 1); idle(2, 1);
    send(8'hF0, 1); send(8'hE0, 1); idle(2, 1);
    send(8'hE0, 1); send(8'hE0, 1); send(8'h6B, 1); idle(2, 1);

    // Asynchronous reset mid-sequence with events queued
    send(8'h1C, 0); send(8'h2C, 0); send(8'hF0, 0);
    #1 reset_n = 1'b0;
    #1;
    check("rst_ev_valid", 32'(bus.ev_valid), 32'd0);
    check("rst_level",    32'(bus.level),    32'd0);
    check("rst_seq_err",  32'(bus.seq_err),  32'd0);
    model_reset();
    bus.rx_done_tick = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(8'h1C, 0); idle(2, 1);

    // Random traffic with occasional long silences after a prefix
    for (int n = 0; n < 2500; n++) begin
      int          r;
      logic [7:0]  b;
      bit          tick, rdy, clr;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1: b = 8'hE0;
        2:    b = 8'hF0;
        3:    b = drop_tab[$urandom_range(0, 5)];
        default: b = 8'($urandom());
      endcase
      tick = ($urandom_range(0, 99) < 35);
      rdy  = ($urandom_range(0, 99) < 40);
      clr  = ($urandom_range(0, 99) < 4);
      cycle(tick, b, rdy, clr);
      if ((n % 500) == 250) begin
        send(8'hF0, 0);
        idle(int'($urandom_range(TOUT - 2, TOUT + 3)), 0);
      end
    end
    idle(8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
